// File: rtl/clk_div_pkg.sv
// Shared helpers for the multi-channel clock-enable/divider generator.
// Holds the channel-select width helper, the half-period helper and the per-cycle channel action type.
package clk_div_pkg;

    // What a channel does on the coming edge, in priority order SYNC > STOP > WRAP > COUNT.
    typedef enum logic [1:0] {
        ACT_COUNT = 2'd0,
        ACT_WRAP  = 2'd1,
        ACT_STOP  = 2'd2,
        ACT_SYNC  = 2'd3
    } chan_act_e;

    function automatic int ch_width(input int nch);
        return ($clog2(nch) > 0) ? $clog2(nch) : 1;
    endfunction

    function automatic logic [31:0] ceil_half(input logic [31:0] n);
        return n - (n >> 1);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor, pending flag, registered tick and out.
// Divisor changes only take effect at a period boundary or while stopped, so out never shows a runt.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int WIDTH     = 26,
    parameter int DEFAULT_N = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_n,
    output logic             o_tick,
    output logic             o_out,
    output logic             o_pend
);

    logic [WIDTH-1:0] r_cnt, r_div, r_shadow;
    logic             r_pend, r_tick, r_out;

    logic [WIDTH-1:0] w_cnt_next, w_div_next, w_shadow_next;
    logic             w_pend_next, w_tick_next, w_out_next;
    chan_act_e        w_act;

    always_comb begin
        w_act = ACT_COUNT;
        if (i_en && i_sync)
            w_act = ACT_SYNC;
        else if (!i_en || (r_div == '0))
            w_act = ACT_STOP;
        else if (r_cnt == r_div - WIDTH'(1))
            w_act = ACT_WRAP;
    end

    always_comb begin
        w_cnt_next    = '0;
        w_div_next    = r_div;
        w_shadow_next = r_shadow;
        w_pend_next   = r_pend;
        w_tick_next   = 1'b0;
        w_out_next    = 1'b0;

        // Any boundary (wrap, stop, sync) is a safe point to switch divisors.
        if ((w_act != ACT_COUNT) && r_pend) begin
            w_div_next  = r_shadow;
            w_pend_next = 1'b0;
        end

        case (w_act)
            ACT_COUNT: w_cnt_next  = r_cnt + WIDTH'(1);
            ACT_WRAP:  w_tick_next = 1'b1;
            default:   w_cnt_next  = '0;
        endcase

        w_out_next = (w_act != ACT_STOP) &&
                     (32'(w_cnt_next) < ceil_half(32'(w_div_next)));

        // A load landing on a boundary stays pending for the next one.
        if (i_ld) begin
            w_shadow_next = i_n;
            w_pend_next   = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_div    <= WIDTH'(DEFAULT_N);
            r_shadow <= WIDTH'(DEFAULT_N);
            r_pend   <= 1'b0;
            r_tick   <= 1'b0;
            r_out    <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_div    <= w_div_next;
            r_shadow <= w_shadow_next;
            r_pend   <= w_pend_next;
            r_tick   <= w_tick_next;
            r_out    <= w_out_next;
        end
    end

    assign o_tick = r_tick;
    assign o_out  = r_out;
    assign o_pend = r_pend;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable/divider: load decode plus NCH independent channels.
// Optional CLK_DIV_PHASE_ALIGN_EN adds clk_div_sync to restart every enabled channel in phase.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int WIDTH     = 26,
    parameter int DEFAULT_N = 2
) (
    input  logic                      fsys,
    input  logic                      clk_div_rst_n,
`ifdef CLK_DIV_PHASE_ALIGN_EN
    input  logic                      clk_div_sync,
`endif
    input  logic [NCH-1:0]            clk_div_en,
    input  logic                      clk_div_ld,
    input  logic [ch_width(NCH)-1:0]  clk_div_ch,
    input  logic [WIDTH-1:0]          clk_div_n,
    output logic [NCH-1:0]            clk_div_pend,
    output logic [NCH-1:0]            clk_div_tick,
    output logic [NCH-1:0]            clk_div_out
);

    logic           w_sync;
    logic [NCH-1:0] w_ld;

`ifdef CLK_DIV_PHASE_ALIGN_EN
    assign w_sync = clk_div_sync;
`else
    assign w_sync = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            // Channel numbers at or above NCH match no channel and are dropped.
            assign w_ld[gi] = clk_div_ld && (int'(clk_div_ch) == gi);

            clk_div_chan #(
                .WIDTH     (WIDTH),
                .DEFAULT_N (DEFAULT_N)
            ) u_chan (
                .i_clk   (fsys),
                .i_rst_n (clk_div_rst_n),
                .i_en    (clk_div_en[gi]),
                .i_sync  (w_sync),
                .i_ld    (w_ld[gi]),
                .i_n     (clk_div_n),
                .o_tick  (clk_div_tick[gi]),
                .o_out   (clk_div_out[gi]),
                .o_pend  (clk_div_pend[gi])
            );
        end
    endgenerate

endmodule
